phase_readout: RTL

- Synchronous reader for the coupled-oscillator array.
- Samples the asynchronous phase outputs of NUM_SPINS oscillators against a reference oscillator over a programmable window of clk cycles.
- Counts, per spin, the cycles where the spin mismatches the reference, so software can recover spin orientation.
- Sits beside the coupled-cell array on the AXI clock: configured by the same write interface style, results returned over a simple registered read port.

---
 rtl/phase_readout_if.sv | 23 ++
 rtl/phase_readout.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/phase_readout_if.sv
// Configuration write and registered read bus for phase_readout.
// Master drives strobes and addresses; slave returns read data and status.
interface phase_readout_if;
    logic        wready;
    logic        wr_addr_match;
    logic [31:0] wdata;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        done;

    modport master (
        output wready, wr_addr_match, wdata, rd_en, rd_addr,
        input  rdata, rvalid, busy, done
    );

    modport slave (
        input  wready, wr_addr_match, wdata, rd_en, rd_addr,
        output rdata, rvalid, busy, done
    );
endinterface

// File: rtl/phase_readout.sv
// Oscillator phase readout: counts per-spin mismatches against a reference
// over a programmable window and publishes them through a read port.
module phase_readout #(
    parameter int NUM_SPINS   = 8,
    parameter int CNT_WIDTH   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic [NUM_SPINS-1:0] phase_in,
    input  logic                 ref_in,
    phase_readout_if.slave       bus
);
    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, COUNT, DONE} state_t;

    typedef logic [NUM_SPINS-1:0][CNT_WIDTH-1:0] cnt_arr_t;

    state_t                         state_q, state_d;
    logic [FW-1:0]                  flush_q, flush_d;
    logic [CNT_WIDTH-1:0]           window_q, window_d;
    logic [CNT_WIDTH-1:0]           win_cnt_q, win_cnt_d;
    cnt_arr_t                       cnt_q, cnt_d;
    cnt_arr_t                       snap_q, snap_d;
    logic                           done_q, done_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           rvalid_q;
    logic [SYNC_STAGES-1:0][NUM_SPINS:0] sync_q;

    logic [NUM_SPINS:0]   samp;
    logic [NUM_SPINS-1:0] mismatch;
    logic                 start;
    logic                 busy;
    logic                 unused_wdata;

    assign samp         = sync_q[SYNC_STAGES-1];
    assign mismatch     = samp[NUM_SPINS-1:0] ^ {NUM_SPINS{samp[NUM_SPINS]}};
    assign start        = bus.wready & bus.wr_addr_match;
    assign busy         = (state_q != IDLE);
    assign unused_wdata = ^bus.wdata;

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy;
    assign bus.done   = done_q;

    // Bring async phases and reference into the clk domain.
    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {ref_in, phase_in};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Measurement state and counters.
    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            state_q   <= IDLE;
            flush_q   <= '0;
            window_q  <= '0;
            win_cnt_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            window_q  <= window_d;
            win_cnt_q <= win_cnt_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
        end
    end

    // Next state: a start always wins and discards any run in flight.
    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        done_d    = done_q;
        if (start) begin
            window_d  = bus.wdata[CNT_WIDTH-1:0];
            win_cnt_d = '0;
            cnt_d     = '0;
            flush_d   = '0;
            done_d    = 1'b0;
            state_d   = FLUSH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FLUSH: begin
                    if (flush_q == FW'(SYNC_STAGES - 1)) begin
                        state_d = (window_q == '0) ? DONE : COUNT;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
                COUNT: begin
                    for (int i = 0; i < NUM_SPINS; i++) begin
                        if (mismatch[i] && (cnt_q[i] != '1)) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (win_cnt_q == window_q - CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    snap_d  = cnt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read mux; status reflects state before any same-cycle write.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.rd_en) begin
            rdata_d = '0;
            for (int i = 0; i < NUM_SPINS; i++) begin
                if (bus.rd_addr == 5'(i)) begin
                    rdata_d = 32'(snap_q[i]);
                end
            end
            if (bus.rd_addr == 5'(NUM_SPINS)) begin
                rdata_d     = 32'(window_q);
                rdata_d[31] = done_q;
                rdata_d[30] = busy;
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= bus.rd_en;
        end
    end
endmodule
